// File: rtl/btn_word_pkg.sv
// Shared types and defaults for the button-driven word assembler.
package btn_word_pkg;

  localparam int DEFAULT_DATA_LEN = 48;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  typedef logic [DEFAULT_DATA_LEN-1:0] word_t;

endpackage

// File: rtl/btn_word_assembler_bit_shift_collector.sv
// MSB-first shift register with a saturating bit counter; a bit offered
// while the register is already full is dropped and flagged.
module bit_shift_collector #(
  parameter int DATA_LEN = 48,
  parameter int CNT_W    = $clog2(DATA_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic                shift_bit,
  input  logic                clear,
  output logic [DATA_LEN-1:0] sr,
  output logic [CNT_W-1:0]    bit_cnt,
  output logic                full,
  output logic                drop
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_LEN);

  logic [DATA_LEN-1:0] sr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                full_s;

  // Full flag and overflow-drop detection from the registered count
  always_comb begin
    full_s = (cnt_r == FULL_CNT);
    drop   = shift_en & full_s;
  end

  // Shift register and count: clear first, then accept a bit only while not full
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r  <= {DATA_LEN{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      sr_r  <= {DATA_LEN{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (shift_en && !full_s) begin
      sr_r  <= {sr_r[DATA_LEN-2:0], shift_bit};
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      sr_r  <= sr_r;
      cnt_r <= cnt_r;
    end
  end

  assign sr      = sr_r;
  assign bit_cnt = cnt_r;
  assign full    = full_s;

endmodule

// File: rtl/btn_word_assembler.sv
// Assembles a word from zero/one button pulses and presents it on a
// valid/ready handshake; protocol misuse raises a one-cycle error pulse.
module btn_word_assembler
  import btn_word_pkg::*;
#(
  parameter int DATA_LEN = DEFAULT_DATA_LEN,
  parameter int CNT_W    = $clog2(DATA_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_bit0,
  input  logic                i_bit1,
  input  logic                i_commit,
  input  logic                i_clear,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [CNT_W-1:0]    o_bit_cnt,
  output logic                o_full,
  output logic                o_err
);

  state_t              state_r, state_nxt_s;
  logic [DATA_LEN-1:0] sr_s, data_r;
  logic [CNT_W-1:0]    cnt_s;
  logic                valid_r, err_r;
  logic                full_s, drop_s, load_s;
  logic                conflict_s, commit_take_s, shift_en_s, clear_s, err_s;

  // Qualify button events; clear outranks bits and commit, commit outranks bits
  always_comb begin
    conflict_s    = i_bit0 & i_bit1;
    commit_take_s = i_commit & ~i_clear & (state_r == COLLECT);
    shift_en_s    = (i_bit0 ^ i_bit1) & ~i_clear & ~commit_take_s;
    clear_s       = i_clear | commit_take_s;
  end

  bit_shift_collector #(
    .DATA_LEN (DATA_LEN),
    .CNT_W    (CNT_W)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en_s),
    .shift_bit (i_bit1),
    .clear     (clear_s),
    .sr        (sr_s),
    .bit_cnt   (cnt_s),
    .full      (full_s),
    .drop      (drop_s)
  );

  // Error aggregation: conflicting bits, dropped bit, short or ill-timed commit
  always_comb begin
    err_s = ~i_clear & (conflict_s | drop_s |
                        (i_commit & ((state_r == PRESENT) | ~full_s)));
  end

  // Next state and word-load decision
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      COLLECT: begin
        if (commit_take_s && full_s) begin
          state_nxt_s = PRESENT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      PRESENT: begin
        if (i_ready) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      default: begin
        state_nxt_s = COLLECT;
      end
    endcase
  end

  // State, presented word, valid and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= COLLECT;
      data_r  <= {DATA_LEN{1'b0}};
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s == PRESENT);
      err_r   <= err_s;
      if (load_s) begin
        data_r <= sr_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign o_data    = data_r;
  assign o_valid   = valid_r;
  assign o_err     = err_r;
  assign o_bit_cnt = cnt_s;
  assign o_full    = full_s;

endmodule

// File: tb/tb_btn_word_assembler.sv
// Scoreboard bench: committed words are queued and checked at the handshake.
module tb_btn_word_assembler;
  import btn_word_pkg::*;

  localparam int DL = 48;
  localparam int CW = $clog2(DL + 1);

  logic          clk = 1'b0;
  logic          rst, i_bit0, i_bit1, i_commit, i_clear, i_ready;
  logic [DL-1:0] o_data;
  logic          o_valid, o_full, o_err;
  logic [CW-1:0] o_bit_cnt;

  int    n_checks = 0;
  int    n_errors = 0;
  word_t exp_q[$];

  btn_word_assembler #(.DATA_LEN(DL), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_bit0    (i_bit0),
    .i_bit1    (i_bit1),
    .i_commit  (i_commit),
    .i_clear   (i_clear),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_bit_cnt (o_bit_cnt),
    .o_full    (o_full),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses; returns #1 after the edge with inputs idle
  task automatic cyc(input logic b0, input logic b1, input logic cm, input logic cl);
    i_bit0 = b0; i_bit1 = b1; i_commit = cm; i_clear = cl;
    @(posedge clk); #1;
    i_bit0 = 1'b0; i_bit1 = 1'b0; i_commit = 1'b0; i_clear = 1'b0;
  endtask

  task automatic enter_word(input word_t w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) cyc(~w[i], w[i], 1'b0, 1'b0);
  endtask

  // Inputs are stable between edges, so a valid&&ready seen here is the handshake
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", 64'(o_data), 64'hDEAD);
      end else begin
        chk("accepted_word", 64'(o_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    word_t w;
    rst = 1'b1; i_ready = 1'b0;
    i_bit0 = 1'b0; i_bit1 = 1'b0; i_commit = 1'b0; i_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_cnt", 64'(o_bit_cnt), 64'h0);
    chk("rst_full", 64'(o_full), 64'h0);
    chk("rst_err", 64'(o_err), 64'h0);

    // Full word, ready high: one-cycle valid pulse
    i_ready = 1'b1;
    w = 48'hFF_FF_FF_FF_FF_00;
    enter_word(w, DL);
    chk("t1_cnt48", 64'(o_bit_cnt), 64'd48);
    chk("t1_full", 64'(o_full), 64'h1);
    exp_q.push_back(w);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", 64'(o_valid), 64'h1);
    chk("t1_data", 64'(o_data), 64'(w));
    chk("t1_cnt0", 64'(o_bit_cnt), 64'h0);
    chk("t1_noerr", 64'(o_err), 64'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid_drop", 64'(o_valid), 64'h0);

    // Short word commit
    enter_word(48'h3FF, 10);
    chk("t2_cnt10", 64'(o_bit_cnt), 64'd10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_err", 64'(o_err), 64'h1);
    chk("t2_valid", 64'(o_valid), 64'h0);
    chk("t2_cnt0", 64'(o_bit_cnt), 64'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_err_once", 64'(o_err), 64'h0);

    // Held word under back-pressure while the next word is collected
    i_ready = 1'b0;
    w = 48'h0000_0000_0001;
    enter_word(w, DL);
    exp_q.push_back(w);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_valid", 64'(o_valid), 64'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_commit_present_err", 64'(o_err), 64'h1);
    chk("t3_held_data", 64'(o_data), 64'(w));
    for (int k = 0; k < DL; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      if (k < 20) begin
        chk("t3_hold_valid", 64'(o_valid), 64'h1);
        chk("t3_hold_data", 64'(o_data), 64'(w));
      end
    end
    chk("t3_hold_valid_end", 64'(o_valid), 64'h1);
    chk("t3_cnt48", 64'(o_bit_cnt), 64'd48);
    i_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_accepted", 64'(o_valid), 64'h0);
    chk("t3_cnt_kept", 64'(o_bit_cnt), 64'd48);

    // Overflow bit dropped, word intact
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_err", 64'(o_err), 64'h1);
    chk("t4_cnt", 64'(o_bit_cnt), 64'd48);
    exp_q.push_back(48'hFFFF_FFFF_FFFF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_err_clr", 64'(o_err), 64'h0);
    chk("t4_data", 64'(o_data), 64'hFFFF_FFFF_FFFF);
    chk("t4_valid", 64'(o_valid), 64'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Conflicting bits, then clear beating commit
    enter_word(48'h15, 5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_err", 64'(o_err), 64'h1);
    chk("t5_cnt5", 64'(o_bit_cnt), 64'd5);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_cnt0", 64'(o_bit_cnt), 64'h0);
    chk("t5_noerr", 64'(o_err), 64'h0);
    chk("t5_novalid", 64'(o_valid), 64'h0);

    // Reset in the middle of a pending handshake
    i_ready = 1'b0;
    w = 48'hA5A5_5A5A_C3C3;
    enter_word(w, DL);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_valid", 64'(o_valid), 64'h1);
    chk("t6_data", 64'(o_data), 64'(w));
    enter_word(48'h2AAA_AAAA, 30);
    chk("t6_cnt30", 64'(o_bit_cnt), 64'd30);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t6_rst_valid", 64'(o_valid), 64'h0);
    chk("t6_rst_cnt", 64'(o_bit_cnt), 64'h0);
    chk("t6_rst_data", 64'(o_data), 64'h0);
    i_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_post_valid", 64'(o_valid), 64'h0);

    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
